stopwatch_counter: RTL and testbench
====================================

Name: stopwatch_counter

Overview:
- Time-keeping core of the stopwatch; sits directly downstream of the clock divider.
- Consumes the divider's unit_clock and blink_clock as level signals sampled in the internal_clk domain; they are never used as clocks.
- Maintains an MM:SS BCD count with pause and per-field adjust, and drives digit values plus per-field blank flags to the 7-segment display stage.

Parameters:
- MIN_LIMIT, 59, highest minutes value before wrap to 00 (BCD-legal, 1..99)
- SEC_LIMIT, 59, highest seconds value before wrap to 00 (BCD-legal, 1..99)

Ports:
- internal_clk  input  1  system clock; sole clock of the block
- rst  input  1  asynchronous, active-high reset
- unit_clock  input  1  ~1 Hz square wave from divider (level)
- blink_clock  input  1  ~1 Hz blink square wave from divider (level)
- pause_pulse  input  1  one-cycle pulse (debounced upstream); toggles run/pause
- adj  input  1  level; 1 = adjust mode
- sel  input  1  level; in adjust mode, 0 = minutes field, 1 = seconds field
- min_tens  output  4  BCD minutes tens digit
- min_ones  output  4  BCD minutes ones digit
- sec_tens  output  4  BCD seconds tens digit
- sec_ones  output  4  BCD seconds ones digit
- paused  output  1  1 while paused
- blank_min  output  1  display should blank the minutes digits this cycle
- blank_sec  output  1  display should blank the seconds digits this cycle

Behaviour:
- Reset (async assert): all digits = 0, paused = 0, blank_min = blank_sec = 0. The edge-detect register and the arm flag are cleared. Reset asserted mid-operation clears the block immediately, regardless of tick or pause activity.
- Edge detect: register u_d samples unit_clock each cycle. rise = unit_clock & ~u_d; any_edge = unit_clock ^ u_d.
- Arm flag: set on the first cycle after reset release. No tick is generated before the arm flag is set, so there is no spurious tick if unit_clock = 1 at reset release.
- Tick source:
  - adj = 0: tick = rise (1 Hz).
  - adj = 1: tick = any_edge (2 Hz).
- Tick gating: tick is ignored while paused = 1.
- Latency: digits update on the internal_clk edge at which the tick is detected, i.e. one internal_clk after unit_clock changes.
- Run mode (adj = 0, not paused, tick):
  - Seconds increment BCD.
  - At SEC_LIMIT, seconds wrap to 00 and minutes increment in the same cycle.
  - Minutes at MIN_LIMIT wrap to 00, so 59:59 -> 00:00.
  - No overflow flag.
- Adjust mode (adj = 1, not paused, tick):
  - Only the field chosen by sel increments; it wraps at its limit with no carry into the other field.
  - The non-selected field holds.
  - The seconds field does not advance in normal time while adj = 1.
- Mode changes: adj or sel changes take effect on the next cycle's tick decision, with no partial updates. Leaving adjust mode resumes 1 Hz counting from the current value.
- Pause:
  - pause_pulse toggles paused on the next clock edge.
  - If a tick and pause_pulse coincide, the tick is processed using the pre-toggle paused value, so a tick coinciding with the pause request still counts.
  - Pausing freezes both run and adjust counting.
- Blanking:
  - blank_min = adj & ~sel & blink_clock.
  - blank_sec = adj & sel & blink_clock.
  - Registered, one cycle latency. Both are 0 when adj = 0. Pause does not affect blanking.
- BCD arithmetic:
  - ones == 9 -> ones = 0 and tens + 1.
  - Limit compare is on the full two-digit value.
  - Digits never take values 10..15.

Decomposition:
- Package stopwatch_pkg holds:
  - the BCD digit width constant (4);
  - default limits (59);
  - a two-digit BCD struct typedef {tens, ones}.
- Sub-module bcd_mod_n:
  - Two-digit BCD counter with inputs inc and limit; output wrap (combinational, asserted when inc and at limit).
  - Instantiated twice, for seconds and minutes.
  - In run mode, minutes inc = seconds wrap; in adjust mode, minutes inc = tick & ~sel.

Test Plan:
- Reset, then 65 unit_clock rising edges with adj = 0 -> digits read 01:05, paused = 0; unit_clock held high across reset release -> no tick in the first cycle.
- Preload by running to 59:58, then apply 2 rising edges -> 59:59 then 00:00, wrap in a single cycle.
- pause_pulse at 00:10, then 5 rising edges -> stays 00:10, paused = 1; second pause_pulse plus 3 edges -> 00:13. pause_pulse in the same cycle as a rise -> that tick counts.
- adj = 1, sel = 1 from 00:58 with 3 unit_clock toggles (both edges) -> 00:59, 00:00, 00:01, minutes unchanged. sel = 0 with 4 toggles -> 04:01.
- adj = 1, sel = 0, blink_clock toggling -> blank_min follows blink_clock one cycle later and blank_sec = 0; adj = 0 -> both 0.
- Assert rst mid-count at 12:34 while a tick is pending -> all digits 0 immediately; counting restarts from 00:00 after release.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared BCD types, digit width and default limits for the stopwatch core.
package stopwatch_pkg;
    localparam int DIGIT_W = 4;
    localparam int MIN_LIMIT_DEF = 59;
    localparam int SEC_LIMIT_DEF = 59;
    typedef struct packed {
        logic [DIGIT_W-1:0] tens;
        logic [DIGIT_W-1:0] ones;
    } bcd2_t;
    function automatic bcd2_t to_bcd2(input int v);
        bcd2_t r;
        r.tens = DIGIT_W'(v / 10);
        r.ones = DIGIT_W'(v % 10);
        return r;
    endfunction
endpackage

// File: rtl/bcd_mod_n.sv
// bcd_mod_n: two-digit BCD counter that wraps to 00 after reaching limit.
module bcd_mod_n
    import stopwatch_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  inc,
    input  bcd2_t limit,
    output bcd2_t value,
    output logic  wrap
);
    bcd2_t cnt_q, cnt_d;
    assign wrap  = inc && (cnt_q == limit);
    assign value = cnt_q;
    always_comb begin
        cnt_d = cnt_q;
        if (wrap) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d.ones = (cnt_q.ones == DIGIT_W'(9)) ? '0 : cnt_q.ones + DIGIT_W'(1);
            cnt_d.tens = (cnt_q.ones == DIGIT_W'(9)) ? cnt_q.tens + DIGIT_W'(1) : cnt_q.tens;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/stopwatch_counter.sv
// stopwatch_counter: MM:SS BCD stopwatch with pause, per-field adjust and blink flags.
module stopwatch_counter
    import stopwatch_pkg::*;
#(
    parameter int MIN_LIMIT = MIN_LIMIT_DEF,
    parameter int SEC_LIMIT = SEC_LIMIT_DEF
) (
    input  logic               internal_clk,
    input  logic               rst,
    input  logic               unit_clock,
    input  logic               blink_clock,
    input  logic               pause_pulse,
    input  logic               adj,
    input  logic               sel,
    output logic [DIGIT_W-1:0] min_tens,
    output logic [DIGIT_W-1:0] min_ones,
    output logic [DIGIT_W-1:0] sec_tens,
    output logic [DIGIT_W-1:0] sec_ones,
    output logic               paused,
    output logic               blank_min,
    output logic               blank_sec
);
    localparam bcd2_t MIN_LIM = to_bcd2(MIN_LIMIT);
    localparam bcd2_t SEC_LIM = to_bcd2(SEC_LIMIT);
    logic  u_q, arm_q, paused_q, blank_min_q, blank_sec_q;
    logic  rise, any_edge, tick, sec_inc, min_inc, sec_wrap, unused_min_wrap;
    bcd2_t sec_v, min_v;
    assign rise     = unit_clock & ~u_q;
    assign any_edge = unit_clock ^ u_q;
    // arm_q suppresses a false edge when unit_clock is already high at reset release
    assign tick     = arm_q & ~paused_q & (adj ? any_edge : rise);
    assign sec_inc  = tick & (~adj | sel);
    assign min_inc  = adj ? tick & ~sel : sec_wrap;
    bcd_mod_n u_sec (
        .clk  (internal_clk),
        .rst  (rst),
        .inc  (sec_inc),
        .limit(SEC_LIM),
        .value(sec_v),
        .wrap (sec_wrap)
    );
    bcd_mod_n u_min (
        .clk  (internal_clk),
        .rst  (rst),
        .inc  (min_inc),
        .limit(MIN_LIM),
        .value(min_v),
        .wrap (unused_min_wrap)
    );
    always_ff @(posedge internal_clk or posedge rst) begin
        if (rst) begin
            u_q         <= 1'b0;
            arm_q       <= 1'b0;
            paused_q    <= 1'b0;
            blank_min_q <= 1'b0;
            blank_sec_q <= 1'b0;
        end else begin
            u_q         <= unit_clock;
            arm_q       <= 1'b1;
            paused_q    <= paused_q ^ pause_pulse;
            blank_min_q <= adj & ~sel & blink_clock;
            blank_sec_q <= adj & sel & blink_clock;
        end
    end
    assign min_tens  = min_v.tens;
    assign min_ones  = min_v.ones;
    assign sec_tens  = sec_v.tens;
    assign sec_ones  = sec_v.ones;
    assign paused    = paused_q;
    assign blank_min = blank_min_q;
    assign blank_sec = blank_sec_q;
endmodule

// File: tb/tb_stopwatch_counter.sv
// tb_stopwatch_counter: directed checks of counting, wrap, pause, adjust, blanking and reset.
module tb_stopwatch_counter;
    logic internal_clk = 1'b0;
    logic rst = 1'b1, unit_clock = 1'b1, blink_clock = 1'b0;
    logic pause_pulse = 1'b0, adj = 1'b0, sel = 1'b0;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic paused, blank_min, blank_sec;
    logic [15:0] dig;
    int n_run = 0, n_fail = 0;

    stopwatch_counter dut (
        .internal_clk(internal_clk),
        .rst         (rst),
        .unit_clock  (unit_clock),
        .blink_clock (blink_clock),
        .pause_pulse (pause_pulse),
        .adj         (adj),
        .sel         (sel),
        .min_tens    (min_tens),
        .min_ones    (min_ones),
        .sec_tens    (sec_tens),
        .sec_ones    (sec_ones),
        .paused      (paused),
        .blank_min   (blank_min),
        .blank_sec   (blank_sec)
    );

    always #5 internal_clk = ~internal_clk;
    assign dig = {min_tens, min_ones, sec_tens, sec_ones};

    task automatic cyc();
        @(posedge internal_clk);
        #1;
    endtask

    task automatic pulse(input int n);
        for (int i = 0; i < n; i++) begin
            unit_clock = 1'b1;
            cyc();
            unit_clock = 1'b0;
            cyc();
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_run++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    initial begin
        #2;
        chk("reset_digits", dig, 16'h0000);
        chk("reset_flags", {13'd0, paused, blank_min, blank_sec}, 16'h0000);
        cyc();
        rst = 1'b0;
        cyc();
        chk("no_tick_at_release", dig, 16'h0000);
        cyc();
        chk("no_tick_high_level", dig, 16'h0000);
        unit_clock = 1'b0;
        cyc();
        pulse(65);
        chk("run_65", dig, 16'h0105);
        chk("run_not_paused", {15'd0, paused}, 16'h0000);
        pulse(3533);
        chk("preload_5958", dig, 16'h5958);
        pulse(1);
        chk("to_5959", dig, 16'h5959);
        pulse(1);
        chk("wrap_0000", dig, 16'h0000);
        pulse(10);
        chk("at_0010", dig, 16'h0010);
        pause_pulse = 1'b1;
        cyc();
        pause_pulse = 1'b0;
        chk("paused_set", {15'd0, paused}, 16'h0001);
        pulse(5);
        chk("paused_hold", dig, 16'h0010);
        pause_pulse = 1'b1;
        cyc();
        pause_pulse = 1'b0;
        chk("paused_clr", {15'd0, paused}, 16'h0000);
        pulse(3);
        chk("resume_0013", dig, 16'h0013);
        unit_clock = 1'b1;
        pause_pulse = 1'b1;
        cyc();
        pause_pulse = 1'b0;
        unit_clock = 1'b0;
        chk("coincide_tick", dig, 16'h0014);
        chk("coincide_paused", {15'd0, paused}, 16'h0001);
        cyc();
        pulse(2);
        chk("coincide_hold", dig, 16'h0014);
        pause_pulse = 1'b1;
        cyc();
        pause_pulse = 1'b0;
        pulse(44);
        chk("at_0058", dig, 16'h0058);
        adj = 1'b1;
        sel = 1'b1;
        cyc();
        chk("adj_enter", dig, 16'h0058);
        unit_clock = 1'b1;
        cyc();
        chk("adj_sec_59", dig, 16'h0059);
        unit_clock = 1'b0;
        cyc();
        chk("adj_sec_wrap", dig, 16'h0000);
        unit_clock = 1'b1;
        cyc();
        chk("adj_sec_01", dig, 16'h0001);
        sel = 1'b0;
        cyc();
        chk("adj_sel_switch", dig, 16'h0001);
        for (int i = 0; i < 4; i++) begin
            unit_clock = ~unit_clock;
            cyc();
        end
        chk("adj_min_0401", dig, 16'h0401);
        blink_clock = 1'b1;
        #2;
        chk("blank_latency", {14'd0, blank_min, blank_sec}, 16'h0000);
        cyc();
        chk("blank_min_on", {14'd0, blank_min, blank_sec}, 16'h0002);
        blink_clock = 1'b0;
        cyc();
        chk("blank_min_off", {14'd0, blank_min, blank_sec}, 16'h0000);
        sel = 1'b1;
        blink_clock = 1'b1;
        cyc();
        chk("blank_sec_on", {14'd0, blank_min, blank_sec}, 16'h0001);
        adj = 1'b0;
        cyc();
        chk("blank_run_off", {14'd0, blank_min, blank_sec}, 16'h0000);
        chk("adj_exit_hold", dig, 16'h0401);
        unit_clock = 1'b0;
        cyc();
        pulse(513);
        chk("at_1234", dig, 16'h1234);
        unit_clock = 1'b1;
        #1;
        rst = 1'b1;
        #1;
        chk("async_reset", dig, 16'h0000);
        cyc();
        rst = 1'b0;
        cyc();
        chk("post_reset_no_tick", dig, 16'h0000);
        unit_clock = 1'b0;
        cyc();
        pulse(3);
        chk("restart_0003", dig, 16'h0003);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
